// File: rtl/mdio_slave_responder.sv
// MDIO (Clause 22) PHY-side responder: oversamples MDC/MDIO, decodes frames for
// PHY_ADDR and services them through a strobe-based register-file port.
// Optional feature macro: MDIO_SLAVE_PREAMBLE_SUPPRESS_EN (accept a 1-bit
// preamble after a normally completed frame).
module mdio_slave_responder #(
  parameter logic [4:0]  PHY_ADDR     = 5'd1,
  parameter int unsigned PREAMBLE_LEN = 32
) (
  input  logic        ip_master_clk,
  input  logic        ip_reset_n,
  input  logic        ip_mdio_clk,
  input  logic        ip_mdio_data,
  output logic        op_mdio_data,
  output logic        op_mdio_oe,
  output logic [4:0]  op_reg_addr,
  output logic        op_reg_wr_strobe,
  output logic [15:0] op_reg_wr_data,
  output logic        op_reg_rd_strobe,
  input  logic [15:0] ip_reg_rd_data,
  output logic        op_frame_error
);

  localparam int unsigned PCW = $clog2(PREAMBLE_LEN + 1);

  typedef enum logic [2:0] {
    S_PREAMBLE, S_START, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA_RX, S_DATA_TX
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      mdc_sync_q;
  logic [1:0]      mdio_sync_q;
  logic [3:0]      cnt_q, cnt_d;
  logic [PCW-1:0]  pre_cnt_q, pre_cnt_d;
  logic [PCW-1:0]  pre_min_c;
  logic [14:0]     shift_q, shift_d;
  logic [15:0]     tx_q, tx_d;
  logic            is_read_q, is_read_d;
  logic            hit_q, hit_d;
  logic            tx_last_q, tx_last_d;
  logic            rd_pend_q, rd_pend_d;
  logic [4:0]      addr_q, addr_d;
  logic [15:0]     wr_data_q, wr_data_d;
  logic            wr_stb_q, wr_stb_d;
  logic            rd_stb_q, rd_stb_d;
  logic            err_q, err_d;
  logic            oe_q, oe_d;
  logic            data_q, data_d;
  logic            rise_c, fall_c, bit_c;

  // MDC/MDIO synchronizers; mdc_sync_q[2] is the extra delay stage for edge detection
  always_ff @(posedge ip_master_clk or negedge ip_reset_n) begin
    if (!ip_reset_n) begin
      mdc_sync_q  <= '0;
      mdio_sync_q <= '0;
    end else begin
      mdc_sync_q  <= {mdc_sync_q[1:0], ip_mdio_clk};
      mdio_sync_q <= {mdio_sync_q[0], ip_mdio_data};
    end
  end

  assign rise_c = mdc_sync_q[1] & ~mdc_sync_q[2];
  assign fall_c = ~mdc_sync_q[1] & mdc_sync_q[2];
  assign bit_c  = mdio_sync_q[1];

`ifdef MDIO_SLAVE_PREAMBLE_SUPPRESS_EN
  logic supp_q, supp_d, frame_done_c;

  assign frame_done_c = (rise_c && state_q == S_DATA_RX && cnt_q == 4'd0) ||
                        (fall_c && state_q == S_DATA_TX && tx_last_q);

  // Relaxed-preamble flag: set by a clean frame end, cleared by any abort
  always_comb begin
    supp_d = supp_q;
    if (err_d)             supp_d = 1'b0;
    else if (frame_done_c) supp_d = 1'b1;
  end

  // Relaxed-preamble flag register
  always_ff @(posedge ip_master_clk or negedge ip_reset_n) begin
    if (!ip_reset_n) supp_q <= 1'b0;
    else             supp_q <= supp_d;
  end

  assign pre_min_c = supp_q ? PCW'(1) : PCW'(PREAMBLE_LEN);
`else
  assign pre_min_c = PCW'(PREAMBLE_LEN);
`endif

  // Frame decoder: field sampling at MDC rise, pad updates at MDC fall
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pre_cnt_d = pre_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    is_read_d = is_read_q;
    hit_d     = hit_q;
    tx_last_d = tx_last_q;
    rd_pend_d = rd_stb_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    wr_stb_d  = 1'b0;
    rd_stb_d  = 1'b0;
    err_d     = 1'b0;
    oe_d      = oe_q;
    data_d    = data_q;

    if (rd_pend_q) tx_d = ip_reg_rd_data;

    if (rise_c) begin
      shift_d = {shift_q[13:0], bit_c};
      cnt_d   = cnt_q - 4'd1;
      case (state_q)
        S_PREAMBLE: begin
          if (bit_c) begin
            if (pre_cnt_q < PCW'(PREAMBLE_LEN)) pre_cnt_d = pre_cnt_q + PCW'(1);
          end else if (pre_cnt_q >= pre_min_c) begin
            state_d   = S_START;
            pre_cnt_d = '0;
          end else begin
            pre_cnt_d = '0;
          end
        end
        S_START: begin
          if (bit_c) begin
            state_d = S_OP;
            cnt_d   = 4'd1;
          end else begin
            state_d = S_PREAMBLE;
            err_d   = 1'b1;
          end
        end
        S_OP: begin
          if (cnt_q == 4'd0) begin
            if ({shift_q[0], bit_c} == 2'b10 || {shift_q[0], bit_c} == 2'b01) begin
              is_read_d = shift_q[0];
              state_d   = S_PHYAD;
              cnt_d     = 4'd4;
            end else begin
              state_d = S_PREAMBLE;
              err_d   = 1'b1;
            end
          end
        end
        S_PHYAD: begin
          if (cnt_q == 4'd0) begin
            hit_d   = ({shift_q[3:0], bit_c} == PHY_ADDR);
            state_d = S_REGAD;
            cnt_d   = 4'd4;
          end
        end
        S_REGAD: begin
          if (cnt_q == 4'd0) begin
            addr_d   = {shift_q[3:0], bit_c};
            rd_stb_d = is_read_q & hit_q;
            state_d  = S_TA;
            cnt_d    = 4'd1;
          end
        end
        S_TA: begin
          if (!is_read_q && ((cnt_q == 4'd1 && !bit_c) || (cnt_q == 4'd0 && bit_c))) begin
            state_d = S_PREAMBLE;
            err_d   = 1'b1;
          end else if (cnt_q == 4'd0) begin
            state_d   = is_read_q ? S_DATA_TX : S_DATA_RX;
            cnt_d     = 4'd15;
            tx_last_d = 1'b0;
          end
        end
        S_DATA_RX: begin
          if (cnt_q == 4'd0) begin
            if (hit_q) begin
              wr_data_d = {shift_q, bit_c};
              wr_stb_d  = 1'b1;
            end
            state_d = S_PREAMBLE;
          end
        end
        S_DATA_TX: begin
          if (cnt_q == 4'd0) tx_last_d = 1'b1;
        end
        default: state_d = S_PREAMBLE;
      endcase
    end else if (fall_c) begin
      if (state_q == S_TA && is_read_q && cnt_q == 4'd0 && hit_q) begin
        oe_d   = 1'b1;
        data_d = 1'b0;
      end else if (state_q == S_DATA_TX) begin
        if (tx_last_q) begin
          oe_d      = 1'b0;
          data_d    = 1'b1;
          state_d   = S_PREAMBLE;
          pre_cnt_d = '0;
        end else begin
          if (hit_q) data_d = tx_q[15];
          tx_d = {tx_q[14:0], 1'b0};
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge ip_master_clk or negedge ip_reset_n) begin
    if (!ip_reset_n) begin
      state_q   <= S_PREAMBLE;
      cnt_q     <= '0;
      pre_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= '0;
      is_read_q <= 1'b0;
      hit_q     <= 1'b0;
      tx_last_q <= 1'b0;
      rd_pend_q <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
      wr_stb_q  <= 1'b0;
      rd_stb_q  <= 1'b0;
      err_q     <= 1'b0;
      oe_q      <= 1'b0;
      data_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pre_cnt_q <= pre_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      is_read_q <= is_read_d;
      hit_q     <= hit_d;
      tx_last_q <= tx_last_d;
      rd_pend_q <= rd_pend_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      wr_stb_q  <= wr_stb_d;
      rd_stb_q  <= rd_stb_d;
      err_q     <= err_d;
      oe_q      <= oe_d;
      data_q    <= data_d;
    end
  end

  assign op_mdio_data     = data_q;
  assign op_mdio_oe       = oe_q;
  assign op_reg_addr      = addr_q;
  assign op_reg_wr_strobe = wr_stb_q;
  assign op_reg_wr_data   = wr_data_q;
  assign op_reg_rd_strobe = rd_stb_q;
  assign op_frame_error   = err_q;

endmodule

// File: tb/tb_mdio_slave_responder.sv
// Bench for mdio_slave_responder: bit-level MDIO master at MDC = clk/12, a
// register-file model and a scoreboard of expected writes and read words.
module tb_mdio_slave_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mdc = 1'b1;
  logic        m_oe = 1'b1;
  logic        m_val = 1'b1;
  logic        mdio_pad;
  logic        op_mdio_data, op_mdio_oe, wr_stb, rd_stb, frame_err;
  logic [4:0]  reg_addr;
  logic [15:0] wr_data, rd_data;
  logic [15:0] regfile [32];

  int vectors = 0, miscompares = 0;
  int wr_cnt = 0, rd_cnt = 0, err_cnt = 0, oe_cnt = 0;
  logic [20:0] exp_wr[$];
  logic [15:0] exp_rd[$];
  int          rx_bits[$];

  always #5 clk = ~clk;

  // Pad: slave wins when enabled, else master drive, else pull-up
  assign mdio_pad = op_mdio_oe ? op_mdio_data : (m_oe ? m_val : 1'b1);

  mdio_slave_responder #(.PHY_ADDR(5'd1), .PREAMBLE_LEN(32)) dut (
    .ip_master_clk   (clk),
    .ip_reset_n      (rst_n),
    .ip_mdio_clk     (mdc),
    .ip_mdio_data    (mdio_pad),
    .op_mdio_data    (op_mdio_data),
    .op_mdio_oe      (op_mdio_oe),
    .op_reg_addr     (reg_addr),
    .op_reg_wr_strobe(wr_stb),
    .op_reg_wr_data  (wr_data),
    .op_reg_rd_strobe(rd_stb),
    .ip_reg_rd_data  (rd_data),
    .op_frame_error  (frame_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Register file: read data valid the cycle after the strobe
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regfile[i] <= 16'h1000 + 16'(i);
      regfile[2] <= 16'h1234;
    end else if (wr_stb) begin
      regfile[reg_addr] <= wr_data;
    end
    rd_data <= rd_stb ? regfile[reg_addr] : 16'hDEAD;
  end

  // Output monitor: pops expected writes, counts strobes/errors/oe cycles
  always @(negedge clk) begin
    logic [20:0] e;
    if (wr_stb) begin
      wr_cnt++;
      if (exp_wr.size() == 0) begin
        check_eq("wr_unexpected", 32'(wr_stb), 32'd0);
      end else begin
        e = exp_wr.pop_front();
        check_eq("wr_addr", 32'(reg_addr), 32'(e[20:16]));
        check_eq("wr_data", 32'(wr_data), 32'(e[15:0]));
      end
    end
    if (rd_stb) rd_cnt++;
    if (rd_stb && wr_stb) check_eq("strobe_pair", 32'(wr_stb), 32'd0);
    if (frame_err) err_cnt++;
    if (op_mdio_oe) oe_cnt++;
  end

  // One MDC period: 0 / 1 driven by master, 2 = released (sampled before rise)
  task automatic mdc_bit(input int code);
    mdc   = 1'b0;
    m_oe  = (code != 2);
    m_val = (code == 1);
    repeat (6) @(posedge clk);
    #1;
    if (code == 2) rx_bits.push_back(int'(mdio_pad));
    mdc = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int pre_len, input logic [1:0] op, input logic [4:0] phy,
                            input logic [4:0] regad, input logic [1:0] ta,
                            input logic [15:0] data, input int stop_at);
    int   codes[$];
    logic rd;
    rd = (op == 2'b10);
    rx_bits.delete();
    for (int i = 0; i < pre_len; i++) codes.push_back(1);
    codes.push_back(0);
    codes.push_back(1);
    for (int i = 1; i >= 0; i--) codes.push_back(int'(op[i]));
    for (int i = 4; i >= 0; i--) codes.push_back(int'(phy[i]));
    for (int i = 4; i >= 0; i--) codes.push_back(int'(regad[i]));
    if (rd) begin
      for (int i = 0; i < 18; i++) codes.push_back(2);
      codes.push_back(1);
    end else begin
      for (int i = 1; i >= 0; i--) codes.push_back(int'(ta[i]));
      for (int i = 15; i >= 0; i--) codes.push_back(int'(data[i]));
    end
    for (int i = 0; i < codes.size(); i++) begin
      if (stop_at >= 0 && i >= stop_at) break;
      mdc_bit(codes[i]);
    end
  endtask

  task automatic do_write(input int pre, input logic [4:0] phy, input logic [4:0] regad,
                          input logic [15:0] data, input bit accept);
    int w0, oe0;
    w0  = wr_cnt;
    oe0 = oe_cnt;
    if (accept) exp_wr.push_back({regad, data});
    send_frame(pre, 2'b01, phy, regad, 2'b10, data, -1);
    repeat (2) @(posedge clk);
    #1;
    check_eq("wr_count", 32'(wr_cnt - w0), accept ? 32'd1 : 32'd0);
    check_eq("wr_oe_quiet", 32'(oe_cnt - oe0), 32'd0);
  endtask

  task automatic do_read(input int pre, input logic [4:0] phy, input logic [4:0] regad,
                         input logic [15:0] val, input bit accept);
    int          r0, oe0;
    logic [15:0] word, e;
    r0  = rd_cnt;
    oe0 = oe_cnt;
    if (accept) exp_rd.push_back(val);
    send_frame(pre, 2'b10, phy, regad, 2'b00, 16'h0, -1);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rd_count", 32'(rd_cnt - r0), accept ? 32'd1 : 32'd0);
    if (accept) begin
      check_eq("rd_oe_cycles", 32'(oe_cnt - oe0), 32'd204);
      check_eq("rd_ta_zero", 32'(rx_bits[1]), 32'd0);
      for (int i = 0; i < 16; i++) word[15-i] = rx_bits[2+i][0];
      e = exp_rd.pop_front();
      check_eq("rd_word", 32'(word), 32'(e));
      check_eq("rd_addr", 32'(reg_addr), 32'(regad));
    end else begin
      check_eq("rd_oe_quiet", 32'(oe_cnt - oe0), 32'd0);
    end
    check_eq("rd_oe_end", 32'(op_mdio_oe), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, w0, r0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("rst_oe", 32'(op_mdio_oe), 32'd0);
    check_eq("rst_data", 32'(op_mdio_data), 32'd1);
    check_eq("rst_addr", 32'(reg_addr), 32'd0);
    check_eq("rst_wr_data", 32'(wr_data), 32'd0);
    check_eq("rst_wr_stb", 32'(wr_stb), 32'd0);
    check_eq("rst_rd_stb", 32'(rd_stb), 32'd0);
    check_eq("rst_err", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Basic write and read
    do_write(32, 5'd1, 5'd5, 16'hA5C3, 1'b1);
    check_eq("wr_data_held", 32'(wr_data), 32'h0000A5C3);
    do_read(32, 5'd1, 5'd2, 16'h1234, 1'b1);

    // Foreign PHY address, then valid frames
    do_read(32, 5'd3, 5'd2, 16'h0, 1'b0);
    do_write(32, 5'd1, 5'd9, 16'h3C5A, 1'b1);
    do_read(32, 5'd1, 5'd9, 16'h3C5A, 1'b1);

    // OP = 11 aborts with an error pulse
    e0 = err_cnt; w0 = wr_cnt; r0 = rd_cnt;
    send_frame(32, 2'b11, 5'd1, 5'd4, 2'b10, 16'h0, 36);
    repeat (4) @(posedge clk);
    #1;
    check_eq("op11_err", 32'(err_cnt - e0), 32'd1);
    check_eq("op11_no_stb", 32'((wr_cnt - w0) + (rd_cnt - r0)), 32'd0);

    // 31-bit preamble is ignored
    e0 = err_cnt;
    do_write(31, 5'd1, 5'd4, 16'hBEEF, 1'b0);
    check_eq("short_pre_err", 32'(err_cnt - e0), 32'd0);

    // Write with TA = 00
    e0 = err_cnt; w0 = wr_cnt;
    send_frame(32, 2'b01, 5'd1, 5'd6, 2'b00, 16'h1111, -1);
    repeat (2) @(posedge clk);
    #1;
    check_eq("ta00_err", 32'(err_cnt - e0), 32'd1);
    check_eq("ta00_no_wr", 32'(wr_cnt - w0), 32'd0);

    // Reset during DATA_TX bit 7
    r0 = rd_cnt;
    send_frame(32, 2'b10, 5'd1, 5'd2, 2'b00, 16'h0, 56);
    mdc  = 1'b0;
    m_oe = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("oe_before_rst", 32'(op_mdio_oe), 32'd1);
    check_eq("rst_rd_seen", 32'(rd_cnt - r0), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("oe_async_rst", 32'(op_mdio_oe), 32'd0);
    check_eq("data_async_rst", 32'(op_mdio_data), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    mdc = 1'b1; m_oe = 1'b1; m_val = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    do_write(32, 5'd1, 5'd7, 16'h0F0F, 1'b1);
    do_read(32, 5'd1, 5'd7, 16'h0F0F, 1'b1);

    // Back-to-back write then 1-bit-preamble read
    do_write(32, 5'd1, 5'd3, 16'h5555, 1'b1);
`ifdef MDIO_SLAVE_PREAMBLE_SUPPRESS_EN
    do_read(1, 5'd1, 5'd3, 16'h5555, 1'b1);
`else
    do_read(1, 5'd1, 5'd3, 16'h0, 1'b0);
`endif

    check_eq("sb_wr_empty", 32'(exp_wr.size()), 32'd0);
    check_eq("sb_rd_empty", 32'(exp_rd.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mdio_slave_responder.md
# mdio_slave_responder

PHY-side MDIO (IEEE 802.3 Clause 22) management responder: the opposite end of the MDC/MDIO master built on the MDIO baudrate generator. It oversamples an externally supplied MDC/MDIO pair on the system clock and decodes read and write frames addressed to its PHY address. Writes and reads are issued to a local 32×16 register file through a simple strobe interface, and read data is driven back onto MDIO via a tristate enable. It sits in front of emulated-PHY or loopback register banks and in the MDIO test harness.

## Interface
- `PHY_ADDR`, default `5'd1`: PHY address this block answers to.
- `PREAMBLE_LEN`, default `32`: number of consecutive '1' bits required before a start-of-frame is accepted.
- `ip_master_clk`  in  1  system clock; all logic is in this domain.
- `ip_reset_n`  in  1  reset; **asynchronous, active-low**.
- `ip_mdio_clk`  in  1  MDC from the master; asynchronous, 2-FF synchronized internally.
- `ip_mdio_data`  in  1  MDIO pad input; asynchronous, 2-FF synchronized on the same chain timing as MDC.
- `op_mdio_data`  out  1  MDIO output value.
- `op_mdio_oe`  out  1  MDIO output enable (1 = drive pad).
- `op_reg_addr`  out  5  REGAD of the current or last decoded frame.
- `op_reg_wr_strobe`  out  1  one-cycle write pulse.
- `op_reg_wr_data`  out  16  write data, valid while `op_reg_wr_strobe` = 1 and held afterwards.
- `op_reg_rd_strobe`  out  1  one-cycle read-request pulse.
- `ip_reg_rd_data`  in  16  read data, sampled on the cycle after `op_reg_rd_strobe`.
- `op_frame_error`  out  1  one-cycle pulse when a frame is aborted.

## Operation
- **MDC edge detection.** Synchronized MDC is delayed one more register. A rise event R or fall event F is a single cycle with a 0→1 or 1→0 change.
- **Sampling.** Synchronized MDIO is sampled at R. Outputs change only in the cycle after F.
- **State machine:** PREAMBLE, START, OP, PHYAD, REGAD, TA, DATA_RX, DATA_TX.
  - **PREAMBLE:** count consecutive sampled 1s; the counter saturates at `PREAMBLE_LEN`. A sampled 0 with count ≥ `PREAMBLE_LEN` moves to START. A sampled 0 with a lower count clears the count.
  - **START:** a sampled 1 moves to OP (ST = 01). A sampled 0 returns to PREAMBLE with count 0 and pulses `op_frame_error`.
  - **OP:** 2 bits. 10 = read, 01 = write. 00 or 11 abort the frame to PREAMBLE with count 0 and an error pulse.
  - **PHYAD:** 5 bits, MSB first. A match sets the internal `hit` flag.
  - **REGAD:** 5 bits, MSB first.
    - `op_reg_addr` updates at the cycle after the R of the last REGAD bit.
    - If read and `hit`, `op_reg_rd_strobe` pulses in that same cycle. `ip_reg_rd_data` is latched into the TX shift register the following cycle.
  - **TA:** 2 bits.
    - Write: the sampled bits must be 1 then 0. Otherwise abort with an error pulse.
    - Read: the first TA bit is kept high-Z. At the cycle after the F that opens the second TA bit, drive `oe` = 1 and `data` = 0 if `hit`.
  - **DATA_TX (read):** 16 bits. Each F shifts out the next bit, D15 first. At the F following the D0 bit period, `oe` drops to 0. The state then returns to PREAMBLE with count 0.
  - **DATA_RX (write):** 16 bits, MSB first, shifted in at R. After the 16th R:
    - if `hit`, `op_reg_wr_data` updates and `op_reg_wr_strobe` pulses in the same cycle;
    - the state returns to PREAMBLE with count 0.
- **Non-matching PHYAD.** The FSM still tracks the whole frame to stay aligned, but never asserts strobes or `oe`.
- **Bit counter:** 4 bits. It is reloaded on every state entry and decremented at R. Field transitions occur at R when the counter reaches 0.

## Timing
- **Reset values:**
  - `op_mdio_oe` = 0, `op_mdio_data` = 1;
  - all strobes and `op_frame_error` = 0;
  - `op_reg_addr` = 0, `op_reg_wr_data` = 0;
  - state PREAMBLE, preamble count 0.
- **Reset mid-frame:** `oe` drops asynchronously and immediately. No strobe is issued for the interrupted frame.
- **Latency:**
  - pin MDC edge to R/F event: 3 cycles;
  - R/F event to output/strobe: +1 cycle.
  - Drive update therefore lands ≤ 4 cycles after the pin MDC falling edge.
- **MDC phase requirement:** each MDC phase must be ≥ 6 `ip_master_clk` cycles, i.e. the master's T_BAUD must be ≥ 12. Shorter phases are unsupported.
- **Register-file read latency:** fixed at 1 cycle. Data is latched ≥ 1 MDC period before D15 is driven.
- **Strobe pairing:** `op_reg_rd_strobe` and `op_reg_wr_strobe` are never asserted in the same cycle.

## Configuration
- **`MDIO_SLAVE_PREAMBLE_SUPPRESS_EN` defined:**
  - after a frame completes normally (read or write, either address), the next start is accepted after a single sampled 1 (minimum preamble = 1);
  - any abort or reset restores the `PREAMBLE_LEN` requirement.
- **Undefined:** `PREAMBLE_LEN` ones are always required.

## Test plan
- **Write frame:** 32×1, 01, 01, PHYAD 1, REGAD 0x05, TA 10, data 0xA5C3 (MDC = clk/12) -> exactly one `op_reg_wr_strobe` with `op_reg_addr` = 5 and `op_reg_wr_data` = 0xA5C3; `oe` stays 0 throughout.
- **Read frame:** REGAD 0x02, register file returns 0x1234 one cycle after `op_reg_rd_strobe` -> `oe` = 1 for 17 MDC periods; the master samples 0 then 0x1234 MSB first; `oe` = 0 afterwards.
- **PHYAD mismatch:** read to PHYAD 3 -> no strobes, `oe` never 1. An immediately following valid frame to PHYAD 1 is decoded correctly.
- **Short preamble / bad fields:**
  - 31 ones then ST -> ignored, no strobe;
  - OP = 11 -> `op_frame_error` pulse;
  - write with TA = 00 -> error pulse and no write strobe.
- **Reset mid-read:** assert `ip_reset_n` = 0 during DATA_TX bit 7 -> `oe` = 0 within the same cycle. After release, a full valid frame works.
- **Preamble suppression:** back-to-back write then read with 1-bit preamble -> read is accepted with macro defined, ignored with macro undefined.
